// File: rtl/sample_sequencer_if.sv
// ADC-side and CAS/theta-side handshake bundle for sample_sequencer.
// The sequencer takes the master modport, the converter/downstream side takes slave.
interface sample_sequencer_if #(
  parameter int W = 12
);
  logic [W-1:0] adc_i;
  logic [W-1:0] adc_v;
  logic         eoc;
  logic         start_adc;
  logic [W-1:0] i_out;
  logic [W-1:0] v_out;
  logic         valid_i;
  logic         valid_v;
  logic         ack_cas_i;
  logic         ack_cas_v;
  logic         ack_theta_i;
  logic         ack_theta_v;

  modport master (
    output start_adc, i_out, v_out, valid_i, valid_v,
    input  adc_i, adc_v, eoc, ack_cas_i, ack_cas_v, ack_theta_i, ack_theta_v
  );

  modport slave (
    input  start_adc, i_out, v_out, valid_i, valid_v,
    output adc_i, adc_v, eoc, ack_cas_i, ack_cas_v, ack_theta_i, ack_theta_v
  );
endinterface

// File: rtl/sample_sequencer.sv
// Periodic I/V ADC sampling loop: start conversion, capture on EOC, offer to CAS, wait for theta.
// Optional EOC watchdog enabled by defining SEQ_EOC_TIMEOUT_EN (sets sticky err, drops the sample).
module sample_sequencer #(
  parameter int W       = 12,
  parameter int PERIOD  = 2000,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt,
  sample_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_START      = 3'd1;
  localparam logic [2:0] S_WAIT_EOC   = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT_THETA = 3'd4;
  localparam logic [2:0] S_HOLD       = 3'd5;

  localparam int PW = $clog2(PERIOD);

  logic [2:0]       state, state_nxt;
  logic [PW-1:0]    period_cnt;
  logic             en_q;
  logic             valid_i, valid_v;
  logic             theta_i, theta_v;
  logic [W-1:0]     i_q, v_q;
  logic [CNT_W-1:0] cnt;
  logic             eoc_hit, eoc_timeout, cas_done, theta_done;

  assign eoc_hit    = (state == S_WAIT_EOC) && bus.eoc;
  assign cas_done   = (!valid_i || bus.ack_cas_i) && (!valid_v || bus.ack_cas_v);
  assign theta_done = (theta_i || bus.ack_theta_i) && (theta_v || bus.ack_theta_v);

`ifdef SEQ_EOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] eoc_wait;
  logic          err_q;

  assign eoc_timeout = (state == S_WAIT_EOC) && !bus.eoc && (eoc_wait == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_wait <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_START)
        eoc_wait <= '0;
      else if (state == S_WAIT_EOC && !bus.eoc)
        eoc_wait <= eoc_wait + 1'b1;
      // A timeout in the same cycle as clr_err must leave the flag set.
      if (eoc_timeout)
        err_q <= 1'b1;
      else if (clr_err)
        err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign eoc_timeout    = 1'b0;
  assign err            = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (en_q) state_nxt = S_START;
      S_START:      state_nxt = S_WAIT_EOC;
      S_WAIT_EOC:   if (bus.eoc) state_nxt = S_ISSUE;
                    else if (eoc_timeout) state_nxt = S_HOLD;
      S_ISSUE:      if (cas_done) state_nxt = S_WAIT_THETA;
      S_WAIT_THETA: if (theta_done) state_nxt = S_HOLD;
      S_HOLD:       if (period_cnt == '0) state_nxt = en ? S_START : S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      period_cnt <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= en;
      // Loading on START entry makes the counter hit zero PERIOD-1 cycles later,
      // so a HOLD exit at zero lands the next START exactly PERIOD cycles on.
      if (state_nxt == S_START)
        period_cnt <= PW'(PERIOD - 1);
      else if (period_cnt != '0)
        period_cnt <= period_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      v_q     <= '0;
      valid_i <= 1'b0;
      valid_v <= 1'b0;
    end else if (eoc_hit) begin
      i_q     <= bus.adc_i;
      v_q     <= bus.adc_v;
      valid_i <= 1'b1;
      valid_v <= 1'b1;
    end else begin
      if (valid_i && bus.ack_cas_i) valid_i <= 1'b0;
      if (valid_v && bus.ack_cas_v) valid_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      theta_i <= 1'b0;
      theta_v <= 1'b0;
      cnt     <= '0;
    end else if (state == S_WAIT_THETA) begin
      if (theta_done) begin
        theta_i <= 1'b0;
        theta_v <= 1'b0;
        cnt     <= cnt + 1'b1;
      end else begin
        theta_i <= theta_i | bus.ack_theta_i;
        theta_v <= theta_v | bus.ack_theta_v;
      end
    end
  end

  assign bus.start_adc = (state == S_START);
  assign bus.i_out     = i_q;
  assign bus.v_out     = v_q;
  assign bus.valid_i   = valid_i;
  assign bus.valid_v   = valid_v;
  assign busy          = (state != S_IDLE);
  assign sample_cnt    = cnt;

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: randomized handshakes against a timing/count model.
// The model tracks expected START times, sample count and captured data from the stimulus alone.
module tb_sample_sequencer;

  localparam int W       = 12;
  localparam int PERIOD  = 2000;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr_err;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] sample_cnt;

  sample_sequencer_if #(.W(W)) bus ();

  sample_sequencer #(.W(W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr_err    (clr_err),
    .busy       (busy),
    .err        (err),
    .sample_cnt (sample_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               exp_start = -1;  // -1: next START time not predicted (loop restarted from IDLE)

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic wait_start(output int t);
    t = -1;
    for (int k = 0; k < PERIOD + 50; k++) begin
      @(negedge clk);
      if (bus.start_adc === 1'b1) break;
    end
    n_cmp++;
    if (bus.start_adc !== 1'b1) begin
      n_bad++;
      $display("FAIL start_wait: start_adc=%b after %0d cycles, required 1", bus.start_adc, PERIOD + 50);
    end else begin
      t = cyc;
      if (exp_start >= 0) begin
        n_cmp++;
        if (t !== exp_start) begin
          n_bad++;
          $display("FAIL start_time: start_adc at cycle %0d, required %0d", t, exp_start);
        end
      end
    end
  endtask

  // One complete sample; latencies are counted in cycles from the first cycle of each phase.
  task automatic run_sample(input logic [W-1:0] di, input logic [W-1:0] dv, input int ed,
                            input int ci, input int cv, input int ti, input int tv,
                            input bit drop_en, output int t0, output int h);
    logic [CNT_W-1:0] old_cnt, want_cnt;
    logic             want_vi, want_vv;
    int               mx, mt;
    h = -1;
    wait_start(t0);
    if (t0 < 0) return;
    old_cnt = exp_cnt;
    mx = imax(ci, cv);
    mt = imax(ti, tv);
    for (int k = 1; k <= ed; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (bus.start_adc !== 1'b0) begin
          n_bad++;
          $display("FAIL start_pulse: start_adc=%b one cycle after START, required 0", bus.start_adc);
        end
      end
      bus.eoc   = (k == ed);
      bus.adc_i = (k == ed) ? di : W'($urandom);
      bus.adc_v = (k == ed) ? dv : W'($urandom);
    end
    for (int j = 0; j <= mx + 1; j++) begin
      @(negedge clk);
      want_vi = (j <= ci);
      want_vv = (j <= cv);
      n_cmp++;
      if (bus.valid_i !== want_vi) begin
        n_bad++;
        $display("FAIL valid_i: cycle %0d of issue valid_i=%b, required %b", j, bus.valid_i, want_vi);
      end
      n_cmp++;
      if (bus.valid_v !== want_vv) begin
        n_bad++;
        $display("FAIL valid_v: cycle %0d of issue valid_v=%b, required %b", j, bus.valid_v, want_vv);
      end
      if (j <= mx) begin
        n_cmp++;
        if ({bus.i_out, bus.v_out} !== {di, dv}) begin
          n_bad++;
          $display("FAIL issue_data: i_out=%h v_out=%h, required %h %h", bus.i_out, bus.v_out, di, dv);
        end
      end
      if (drop_en && j == 0) en = 1'b0;
      // Stray acks after acceptance and stray EOCs outside WAIT_EOC must be ignored.
      bus.ack_cas_i = (j == ci) || (j > ci && j <= mx && $urandom_range(0, 1) == 1);
      bus.ack_cas_v = (j == cv) || (j > cv && j <= mx && $urandom_range(0, 1) == 1);
      bus.eoc       = (j <= mx) && ($urandom_range(0, 1) == 1);
      bus.adc_i     = W'($urandom);
      bus.adc_v     = W'($urandom);
    end
    for (int w = 0; w <= mt + 1; w++) begin
      if (w > 0) @(negedge clk);
      want_cnt = (w <= mt) ? old_cnt : old_cnt + 1'b1;
      n_cmp++;
      if (sample_cnt !== want_cnt) begin
        n_bad++;
        $display("FAIL sample_cnt: theta cycle %0d sample_cnt=%0d, required %0d", w, sample_cnt, want_cnt);
      end
      bus.ack_theta_i = (w == ti);
      bus.ack_theta_v = (w == tv);
      bus.eoc         = (w <= mt) && ($urandom_range(0, 3) == 0);
    end
    exp_cnt = old_cnt + 1'b1;
    h = cyc;
    n_cmp++;
    if ({bus.i_out, bus.v_out} !== {di, dv}) begin
      n_bad++;
      $display("FAIL hold_data: i_out=%h v_out=%h, required %h %h", bus.i_out, bus.v_out, di, dv);
    end
    exp_start = en ? imax(t0 + PERIOD, h + 1) : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b1;
    #3;
    n_cmp++;
    if ({busy, err, bus.start_adc, bus.valid_i, bus.valid_v} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/err/start/valid=%b, required 00000",
               {busy, err, bus.start_adc, bus.valid_i, bus.valid_v});
    end
    n_cmp++;
    if ({bus.i_out, bus.v_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: i_out=%h v_out=%h, required 0 0", bus.i_out, bus.v_out);
    end
    n_cmp++;
    if (sample_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: sample_cnt=%0d, required 0", sample_cnt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.start_adc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: start_adc=%b after first edge, required 0", bus.start_adc);
    end
    exp_cnt = '0;
    exp_start = -1;
  endtask

  task automatic test_basic;
    int t0, h;
    run_sample(12'h0A5, 12'hF3C, 3, 0, 0, 0, 0, 1'b0, t0, h);
    n_cmp++;
    if (bus.i_out !== 12'h0A5 || bus.v_out !== 12'hF3C) begin
      n_bad++;
      $display("FAIL basic_data: i_out=%h v_out=%h, required 0a5 f3c", bus.i_out, bus.v_out);
    end
    n_cmp++;
    if (sample_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL basic_cnt: sample_cnt=%0d, required 1", sample_cnt);
    end
  endtask

  task automatic test_cas_skew;
    int t0, h;
    run_sample(W'($urandom), W'($urandom), $urandom_range(1, 6), 2, 7,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, t0, h);
  endtask

  task automatic test_theta_skew;
    int t0, h;
    run_sample(W'($urandom), W'($urandom), $urandom_range(1, 6), $urandom_range(0, 4),
               $urandom_range(0, 4), 10, 4, 1'b0, t0, h);
  endtask

  task automatic test_long_sample;
    int t0, h;
    run_sample(W'($urandom), W'($urandom), $urandom_range(1, 6), $urandom_range(0, 4),
               $urandom_range(0, 4), PERIOD + $urandom_range(0, 40), $urandom_range(0, 9), 1'b0, t0, h);
  endtask

  task automatic test_timeout;
    int   t0;
    logic seen;
`ifdef SEQ_EOC_TIMEOUT_EN
    logic [CNT_W-1:0] c0;
    wait_start(t0);
    if (t0 < 0) return;
    c0 = exp_cnt;
    seen = 1'b0;
    while (cyc < t0 + TIMEOUT) begin
      @(negedge clk);
      if (bus.valid_i === 1'b1 || bus.valid_v === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: err=%b at cycle %0d of wait, required 0", err, TIMEOUT - 1);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err: err=%b after %0d cycles (clr_err same cycle), required 1", err, TIMEOUT);
    end
    n_cmp++;
    if (seen || bus.valid_i !== 1'b0 || bus.valid_v !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_valid: valid seen=%b, required 0", seen);
    end
    n_cmp++;
    if (sample_cnt !== c0) begin
      n_bad++;
      $display("FAIL timeout_cnt: sample_cnt=%0d, required %0d", sample_cnt, c0);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err: err=%b after clr_err pulse, required 0", err);
    end
    exp_start = t0 + PERIOD;
`else
    wait_start(t0);
    if (t0 < 0) return;
    seen = 1'b0;
    repeat (PERIOD + 100) begin
      @(negedge clk);
      if (bus.start_adc === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL no_timeout: repeated start=%b busy=%b, required 0 1", seen, busy);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_tied: err=%b, required 0", err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_start = -1;
`endif
  endtask

  task automatic test_en_drop;
    int   t0, h, e;
    logic seen;
    run_sample(W'($urandom), W'($urandom), $urandom_range(1, 6), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b1, t0, h);
    if (h < 0) return;
    e = imax(t0 + PERIOD, h + 1);
    while (cyc < e - 1) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL en_drop_hold: busy=%b one cycle before idle, required 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop_idle: busy=%b at cycle %0d, required 0", busy, e);
    end
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.start_adc === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop_start: start_adc seen=%b while disabled, required 0", seen);
    end
    en = 1'b1;
    exp_start = -1;
  endtask

  task automatic test_reset_mid;
    int         t0;
    logic [W-1:0] di, dv;
    di = W'($urandom) | W'(1);
    dv = W'($urandom) | W'(1);
    wait_start(t0);
    if (t0 < 0) return;
    @(negedge clk);
    bus.eoc = 1'b1; bus.adc_i = di; bus.adc_v = dv;
    @(negedge clk);
    bus.eoc = 1'b0; bus.ack_cas_i = 1'b1; bus.ack_cas_v = 1'b1;
    @(negedge clk);
    bus.ack_cas_i = 1'b0; bus.ack_cas_v = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || {bus.i_out, bus.v_out} !== {di, dv}) begin
      n_bad++;
      $display("FAIL mid_pre: busy=%b i_out=%h v_out=%h, required 1 %h %h", busy, bus.i_out, bus.v_out, di, dv);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, err, bus.start_adc, bus.valid_i, bus.valid_v} !== 5'b0 ||
        {bus.i_out, bus.v_out} !== '0 || sample_cnt !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: ctrl=%b i_out=%h v_out=%h cnt=%0d, required all 0",
               {busy, err, bus.start_adc, bus.valid_i, bus.valid_v}, bus.i_out, bus.v_out, sample_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.start_adc !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_release: start_adc=%b after first edge, required 0", bus.start_adc);
    end
    exp_cnt = '0;
    exp_start = -1;
  endtask

  task automatic test_wrap;
    int t0, h;
    for (int s = 0; s < 16; s++)
      run_sample(W'($urandom), W'($urandom), $urandom_range(1, 8), $urandom_range(0, 6),
                 $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, t0, h);
    n_cmp++;
    if (sample_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL wrap: sample_cnt=%0d after 16 samples, required 0", sample_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
    bus.eoc = 1'b0; bus.adc_i = '0; bus.adc_v = '0;
    bus.ack_cas_i = 1'b0; bus.ack_cas_v = 1'b0;
    bus.ack_theta_i = 1'b0; bus.ack_theta_v = 1'b0;
    test_reset();
    test_basic();
    test_cas_skew();
    test_theta_skew();
    test_long_sample();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
